// File: rtl/io_seq_pkg.sv
// Shared state encoding and default timing for the IO-segment power sequencer.
package io_seq_pkg;

    typedef enum logic [3:0] {
        StOff   = 4'd0,
        StWaitL = 4'd1,
        StRelL  = 4'd2,
        StWaitR = 4'd3,
        StRelR  = 4'd4,
        StOn    = 4'd5,
        StDis   = 4'd6,
        StRet   = 4'd7,
        StFault = 4'd8
    } seq_state_e;

    localparam int unsigned DefDebounce = 4;
    localparam int unsigned DefSettle   = 8;
    localparam int unsigned DefTimeout  = 64;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/io_pg_sync_debounce.sv
// Power-good synchroniser plus saturating debounce; ok_o drops in the same
// cycle the synchronised level goes low.
module io_pg_sync_debounce
    import io_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DefDebounce
) (
    input  logic clk,
    input  logic rst,
    input  logic pg_i,
    output logic ok_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    logic          sync_q1, sync_q2;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q1 <= pg_i;
            sync_q2 <= sync_q1;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!sync_q2) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEBOUNCE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign ok_o = sync_q2 && (cnt_q == CW'(DEBOUNCE));

endmodule

// File: rtl/io_seg_pwr_seq.sv
// Sequences retention release and output-driver enable for the left/right IO
// segments around a VSSIO cut, under a 4-phase req/ack from the power controller.
module io_seg_pwr_seq
    import io_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DefDebounce,
    parameter int unsigned SETTLE   = DefSettle,
    parameter int unsigned TIMEOUT  = DefTimeout
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_on_i,
    output logic       ack_o,
    output logic       busy_o,
    output logic       fault_o,
    input  logic       pg_l_i,
    input  logic       pg_r_i,
    output logic       ret_l_o,
    output logic       ret_r_o,
    output logic       oe_en_l_o,
    output logic       oe_en_r_o,
    output logic [3:0] state_o
);

    localparam int unsigned TW = $clog2(max_u(SETTLE, TIMEOUT) + 1);

    logic          ok_l, ok_r;
    seq_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic          settle_done, timed_out;
    logic          ret_l_q, ret_l_d, ret_r_q, ret_r_d, oe_q, oe_d;
    logic          ack_q, ack_d, busy_q, busy_d, fault_q, fault_d;

    io_pg_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_pg_l (
        .clk  (clk),
        .rst  (rst),
        .pg_i (pg_l_i),
        .ok_o (ok_l)
    );

    io_pg_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_pg_r (
        .clk  (clk),
        .rst  (rst),
        .pg_i (pg_r_i),
        .ok_o (ok_r)
    );

    // Exit fires on the edge where the count would reach the limit.
    assign timer_inc   = timer_q + 1'b1;
    assign settle_done = (timer_inc == TW'(SETTLE));
    assign timed_out   = (timer_inc == TW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOff:   if (req_on_i) state_d = StWaitL;
            StWaitL: begin
                if (!req_on_i)      state_d = StRet;
                else if (ok_l)      state_d = StRelL;
                else if (timed_out) state_d = StFault;
            end
            StRelL: begin
                if (!ok_l)            state_d = StFault;
                else if (!req_on_i)   state_d = StDis;
                else if (settle_done) state_d = StWaitR;
            end
            StWaitR: begin
                if (!req_on_i)      state_d = StRet;
                else if (ok_r)      state_d = StRelR;
                else if (timed_out) state_d = StFault;
            end
            StRelR: begin
                if (!ok_l || !ok_r)   state_d = StFault;
                else if (!req_on_i)   state_d = StDis;
                else if (settle_done) state_d = StOn;
            end
            StOn: begin
                if (!ok_l || !ok_r) state_d = StFault;
                else if (!req_on_i) state_d = StDis;
            end
            StDis:   if (settle_done) state_d = StRet;
            StRet:   state_d = StOff;
            StFault: if (!req_on_i) state_d = StOff;
            default: state_d = StFault;
        endcase
    end

    // Outputs are registered from the next state so they switch on state entry.
    always_comb begin
        ret_l_d = ret_l_q;
        ret_r_d = ret_r_q;
        oe_d    = oe_q;
        ack_d   = ack_q;
        timer_d = (timer_q == '1) ? timer_q : timer_inc;
        if (state_d != state_q) begin
            timer_d = '0;
            case (state_d)
                StRelL: ret_l_d = 1'b0;
                StRelR: ret_r_d = 1'b0;
                StOn: begin
                    oe_d  = 1'b1;
                    ack_d = 1'b1;
                end
                StDis: oe_d = 1'b0;
                StRet: begin
                    ret_l_d = 1'b1;
                    ret_r_d = 1'b1;
                end
                StOff, StFault: begin
                    ret_l_d = 1'b1;
                    ret_r_d = 1'b1;
                    oe_d    = 1'b0;
                    ack_d   = 1'b0;
                end
                default: ;
            endcase
        end
        busy_d  = (state_d == StWaitL) || (state_d == StRelL) || (state_d == StWaitR) ||
                  (state_d == StRelR) || (state_d == StDis) || (state_d == StRet);
        fault_d = (state_d == StFault);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOff;
            timer_q <= '0;
            ret_l_q <= 1'b1;
            ret_r_q <= 1'b1;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ret_l_q <= ret_l_d;
            ret_r_q <= ret_r_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign ret_l_o   = ret_l_q;
    assign ret_r_o   = ret_r_q;
    assign oe_en_l_o = oe_q;
    assign oe_en_r_o = oe_q;
    assign ack_o     = ack_q;
    assign busy_o    = busy_q;
    assign fault_o   = fault_q;
    assign state_o   = state_q;

endmodule
